// File: rtl/dmem_responder_pkg.sv
// Shared bus definitions for the Dcache<->Dmem interface.
//   bus_cmd_e              : bus command encoding (3 is unused and treated as BUS_NONE)
//   MEM_LATENCY_IN_CYCLES  : default acceptance-to-completion latency
//   tag_t / cpl_t          : transaction tag and completion pipeline entry
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_cmd_e;

    localparam int MEM_LATENCY_IN_CYCLES = 20;
    localparam int TAG_W                 = 4;
    localparam int NUM_TAGS              = 15;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic        vld;
        tag_t        tag;
        logic [63:0] data;
    } cpl_t;

    function automatic logic is_mem_cmd(input logic [1:0] cmd);
        return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
    endfunction

endpackage

// File: rtl/dmem_responder_tag_pool.sv
// Transaction tag allocator: busy bit per usable tag 1..NUM_TAGS, lowest free tag first.
//   clock, reset  : clock, synchronous active-high reset (frees every tag)
//   alloc_i       : mark free_tag_o busy at this edge
//   free_i        : release free_tag_i at this edge
//   free_tag_i    : tag being released
//   avail_o       : at least one tag is free
//   free_tag_o    : lowest-numbered free tag (0 when none)
module dmem_tag_pool
    import dmem_responder_pkg::*;
#(
    parameter int N_TAGS = NUM_TAGS
) (
    input  logic clock,
    input  logic reset,
    input  logic alloc_i,
    input  logic free_i,
    input  tag_t free_tag_i,
    output logic avail_o,
    output tag_t free_tag_o
);

    logic [N_TAGS:1] busy_q, busy_d;

    // Scan downward so the lowest free tag is the one that sticks.
    always_comb begin
        avail_o    = 1'b0;
        free_tag_o = '0;
        for (int t = N_TAGS; t >= 1; t--) begin
            if (!busy_q[t]) begin
                avail_o    = 1'b1;
                free_tag_o = tag_t'(t);
            end
        end
    end

    // The tag being freed is still busy this cycle, so it can never equal the
    // tag being allocated; the two updates touch different bits.
    always_comb begin
        busy_d = busy_q;
        for (int t = 1; t <= N_TAGS; t++) begin
            if (free_i && free_tag_i == tag_t'(t))
                busy_d[t] = 1'b0;
            if (alloc_i && free_tag_o == tag_t'(t))
                busy_d[t] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the Dcache<->Dmem bus. Accepts LOAD/STORE, returns a tag
// combinationally, and broadcasts {tag, data} exactly MEM_LATENCY cycles later.
//   clock, reset          : clock, synchronous active-high reset (memory contents kept)
//   Dcache2Dmem_command   : BUS_NONE / BUS_LOAD / BUS_STORE
//   Dcache2Dmem_addr      : byte address, low 3 bits ignored, aliases modulo memory size
//   Dcache2Dmem_data      : store data
//   Dmem2Dcache_response  : tag allocated this cycle, 0 = rejected / no request
//   Dmem2Dcache_tag       : tag completing this cycle, 0 = idle
//   Dmem2Dcache_data      : load data of the completing tag, 0 for stores / idle
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_IN_CYCLES,
    parameter int MEM_WORDS   = 8192
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Dcache2Dmem_command,
    input  logic [63:0] Dcache2Dmem_addr,
    input  logic [63:0] Dcache2Dmem_data,
    output logic [3:0]  Dmem2Dcache_response,
    output logic [3:0]  Dmem2Dcache_tag,
    output logic [63:0] Dmem2Dcache_data
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [63:0]      mem_q [MEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic             avail, accept, is_store;
    tag_t             free_tag;
    cpl_t             pipe_q [MEM_LATENCY];
    cpl_t             stage_d, cpl;

    assign idx      = Dcache2Dmem_addr[3 +: IDX_W];
    assign is_store = (Dcache2Dmem_command == BUS_STORE);
    assign accept   = !reset && is_mem_cmd(Dcache2Dmem_command) && avail;
    assign cpl      = pipe_q[MEM_LATENCY-1];

    dmem_tag_pool #(.N_TAGS(NUM_TAGS)) u_pool (
        .clock      (clock),
        .reset      (reset),
        .alloc_i    (accept),
        .free_i     (cpl.vld),
        .free_tag_i (cpl.tag),
        .avail_o    (avail),
        .free_tag_o (free_tag)
    );

    // Load data is snapshotted here, before a store at this same edge could change it.
    always_comb begin
        stage_d      = '0;
        stage_d.vld  = accept;
        stage_d.tag  = free_tag;
        stage_d.data = (accept && !is_store) ? mem_q[idx] : 64'h0;
    end

    always_ff @(posedge clock) begin
        if (accept && is_store)
            mem_q[idx] <= Dcache2Dmem_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= stage_d;
            for (int i = 1; i < MEM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign Dmem2Dcache_response = accept ? free_tag : '0;
    assign Dmem2Dcache_tag      = (cpl.vld && !reset) ? cpl.tag  : '0;
    assign Dmem2Dcache_data     = (cpl.vld && !reset) ? cpl.data : 64'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int LAT   = 20;
    localparam int WORDS = 8192;
    localparam int NT    = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd   = 2'h0;
    logic [63:0] addr  = '0;
    logic [63:0] wdata = '0;
    logic [3:0]  resp, otag;
    logic [63:0] odata;

    always #5 clock = ~clock;

    dmem_responder #(.MEM_LATENCY(LAT), .MEM_WORDS(WORDS)) dut (
        .clock                (clock),
        .reset                (reset),
        .Dcache2Dmem_command  (cmd),
        .Dcache2Dmem_addr     (addr),
        .Dcache2Dmem_data     (wdata),
        .Dmem2Dcache_response (resp),
        .Dmem2Dcache_tag      (otag),
        .Dmem2Dcache_data     (odata)
    );

    // Reference model: free-tag set, flat word store, and a queue of
    // completions each stamped with the cycle it is due.
    typedef struct {
        int          due;
        int          tag;
        logic [63:0] data;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          mbusy [1:NT];
    logic [63:0] mmem  [int];
    exp_t        q [$];

    logic [3:0]  r, t;
    logic [63:0] od;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 1; i <= NT; i++) if (!mbusy[i]) return i;
        return 0;
    endfunction

    // One bus cycle: drive, sample at negedge, check, advance the model.
    task automatic step(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d,
                        output logic [3:0] ro, output logic [3:0] to, output logic [63:0] dout);
        int          er, idx, freed;
        exp_t        e;
        logic [63:0] xt, xd;
        cmd = c; addr = a; wdata = d;
        @(negedge clock);
        ro = resp; to = otag; dout = odata;
        er = (c == 2'h1 || c == 2'h2) ? lowest_free() : 0;
        chk("resp", 64'(ro), 64'(er));
        xt = '0; xd = '0; freed = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            xt = 64'(e.tag); xd = e.data; freed = e.tag;
        end
        chk("tag", 64'(to), xt);
        chk("data", dout, xd);
        idx = int'((a >> 3) & 64'(WORDS - 1));
        if (er != 0) begin
            mbusy[er] = 1'b1;
            e.due  = cyc + LAT;
            e.tag  = er;
            e.data = (c == 2'h1) ? mmem[idx] : 64'h0;
            q.push_back(e);
            if (c == 2'h2) mmem[idx] = d;
        end
        if (freed != 0) mbusy[freed] = 1'b0;
        @(posedge clock); #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd = 2'h1; addr = 64'h100;
        @(negedge clock);
        chk("rst_resp", 64'(resp), 64'h0);
        chk("rst_tag", 64'(otag), 64'h0);
        chk("rst_data", odata, 64'h0);
        @(posedge clock); #1;
        q.delete();
        for (int i = 1; i <= NT; i++) mbusy[i] = 1'b0;
        reset = 1'b0; cmd = 2'h0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'h0, 64'h0, 64'h0, r, t, od);
    endtask

    initial begin
        logic [63:0] a;
        int          pool [8];

        do_reset();
        do_reset();

        // Test 1: preload then single load, broadcast only at +20
        step(2'h2, 64'h100, 64'hDEADBEEF, r, t, od);
        idle(22);
        step(2'h1, 64'h100, 64'h0, r, t, od);
        chk("t1_resp", 64'(r), 64'h1);
        for (int i = 1; i < LAT; i++) begin
            step(2'h0, 64'h0, 64'h0, r, t, od);
            chk("t1_quiet", 64'(t), 64'h0);
        end
        step(2'h0, 64'h0, 64'h0, r, t, od);
        chk("t1_tag", 64'(t), 64'h1);
        chk("t1_data", od, 64'hDEADBEEF);
        step(2'h0, 64'h0, 64'h0, r, t, od);
        chk("t1_after", 64'(t), 64'h0);
        idle(2);

        // Test 2: store then load same word on the next cycle
        step(2'h2, 64'h208, 64'h55, r, t, od);
        chk("t2_resp_st", 64'(r), 64'h1);
        step(2'h1, 64'h208, 64'h0, r, t, od);
        chk("t2_resp_ld", 64'(r), 64'h2);
        idle(LAT - 2);
        step(2'h0, 64'h0, 64'h0, r, t, od);
        chk("t2_st_tag", 64'(t), 64'h1);
        chk("t2_st_data", od, 64'h0);
        step(2'h0, 64'h0, 64'h0, r, t, od);
        chk("t2_ld_tag", 64'(t), 64'h2);
        chk("t2_ld_data", od, 64'h55);
        idle(2);

        // Test 3: pool exhaustion and tag reuse
        for (int i = 0; i < 16; i++) begin
            step(2'h1, 64'h100, 64'h0, r, t, od);
            chk("t3_resp", 64'(r), (i < 15) ? 64'(i + 1) : 64'h0);
        end
        idle(LAT - 16);
        step(2'h0, 64'h0, 64'h0, r, t, od);
        chk("t3_bcast", 64'(t), 64'h1);
        step(2'h1, 64'h100, 64'h0, r, t, od);
        chk("t3_reuse", 64'(r), 64'h1);
        idle(LAT + 2);

        // Test 4: reset mid-flight drops everything
        for (int i = 0; i < 3; i++) step(2'h1, 64'h100, 64'h0, r, t, od);
        idle(2);
        do_reset();
        for (int i = 0; i < LAT + 5; i++) begin
            step(2'h0, 64'h0, 64'h0, r, t, od);
            chk("t4_notag", 64'(t), 64'h0);
        end
        step(2'h1, 64'h100, 64'h0, r, t, od);
        chk("t4_resp", 64'(r), 64'h1);
        idle(LAT + 2);

        // Test 5: offset/aliasing and load snapshot vs later store
        step(2'h2, 64'h300, 64'h7, r, t, od);
        idle(LAT + 2);
        step(2'h1, 64'h105, 64'h0, r, t, od);
        step(2'h1, 64'h10100, 64'h0, r, t, od);
        step(2'h1, 64'h300, 64'h0, r, t, od);
        step(2'h2, 64'h300, 64'h9, r, t, od);
        idle(LAT - 4);
        step(2'h0, 64'h0, 64'h0, r, t, od);
        chk("t5_off", od, 64'hDEADBEEF);
        step(2'h0, 64'h0, 64'h0, r, t, od);
        chk("t5_alias", od, 64'hDEADBEEF);
        step(2'h0, 64'h0, 64'h0, r, t, od);
        chk("t5_snap", od, 64'h7);
        idle(3);
        step(2'h1, 64'h300, 64'h0, r, t, od);
        idle(LAT - 1);
        step(2'h0, 64'h0, 64'h0, r, t, od);
        chk("t5_new", od, 64'h9);
        idle(2);

        // Test 6: random stream over a small set of initialised words
        for (int i = 0; i < 8; i++) begin
            pool[i] = 64 + i * 37;
            a = {$urandom, $urandom};
            a[15:3] = 13'(pool[i]);
            step(2'h2, a, {$urandom, $urandom}, r, t, od);
        end
        idle(LAT + 2);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                a = {$urandom, $urandom};
                a[15:3] = 13'(pool[$urandom_range(0, 7)]);
                step(2'($urandom_range(0, 3)), a, {$urandom, $urandom}, r, t, od);
            end
        end
        idle(LAT + 2);
        chk("t6_drained", 64'(q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
